sr_math_func: RTL and testbench

- Multi-cycle arithmetic unit, directly downstream of the register-file read ports and upstream of the write-back mux.
- Consumes rs1/rs2 register values on the FUNC opcode and returns a 16-bit result that the core zero-extends and writes to rd.
- Computes y = (a[7:0] * a[7:0] + isqrt(b)) mod 2^16.
- Uses an iterative restoring integer square root followed by a shift-add multiplier, sharing one FSM.
- Fixed latency, so the control stage can stall the PC on busy_o alone.

---
 rtl/sr_math_func.sv | 97 +++++++++
 tb/tb_sr_math_func.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sr_math_func.sv
// sr_math_func: y = (a[MUL_W-1:0]^2 + isqrt(b)) mod 2^16, one FSM sharing a restoring isqrt and a shift-add multiplier.
module sr_math_func #(
    parameter int MUL_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] a_bi,
    input  logic [31:0] b_bi,
    output logic [15:0] y_bo,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE, SQRT, MUL, ADD} state_t;

    state_t               state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [31:0]          b_q, b_d;
    logic [17:0]          rem_q, rem_d, rem_sh, trial;
    logic [15:0]          root_q, root_d, y_q, y_d;
    logic [2*MUL_W-1:0]   mcand_q, mcand_d, prod_q, prod_d;
    logic [MUL_W-1:0]     mplier_q, mplier_d;
    logic                 fits;

    // Partial remainder never exceeds 16 bits before the final shift, so the top bits drop out safely.
    assign rem_sh = (rem_q << 2) | {16'd0, b_q[31:30]};
    assign trial  = {root_q, 2'b01};
    assign fits   = rem_sh >= trial;
    assign busy_o = state_q != IDLE;
    assign y_bo   = y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            y_q      <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            y_q      <= y_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        b_d      = b_q;
        rem_d    = rem_q;
        root_d   = root_q;
        y_d      = y_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d  = SQRT;
                cnt_d    = '0;
                b_d      = b_bi;
                mcand_d  = (2*MUL_W)'(a_bi[MUL_W-1:0]);
                mplier_d = a_bi[MUL_W-1:0];
                rem_d    = '0;
                root_d   = '0;
                prod_d   = '0;
            end
            SQRT: begin
                b_d     = b_q << 2;
                rem_d   = fits ? rem_sh - trial : rem_sh;
                root_d  = {root_q[14:0], fits};
                cnt_d   = cnt_q == 5'd15 ? 5'd0 : cnt_q + 5'd1;
                state_d = cnt_q == 5'd15 ? MUL : SQRT;
            end
            MUL: begin
                prod_d   = mplier_q[0] ? prod_q + mcand_q : prod_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q == 5'(MUL_W-1) ? 5'd0 : cnt_q + 5'd1;
                state_d  = cnt_q == 5'(MUL_W-1) ? ADD : MUL;
            end
            ADD: begin
                y_d     = 16'(prod_q) + root_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sr_math_func.sv
// tb_sr_math_func: directed vectors against a latency/arithmetic model of sr_math_func.
module tb_sr_math_func;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start_i = 0;
    logic [31:0] a_bi = 0;
    logic [31:0] b_bi = 0;
    logic [15:0] y_bo;
    logic        busy_o;

    int n_cmp = 0;
    int n_bad = 0;
    int n;

    int          m_left = 0;
    logic [15:0] m_y = 0;
    logic [15:0] m_pend = 0;

    sr_math_func dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .a_bi(a_bi), .b_bi(b_bi), .y_bo(y_bo), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned isqrt(longint unsigned b);
        longint unsigned lo = 0, hi = 65535, mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= b) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic logic [15:0] f(logic [31:0] a, logic [31:0] b);
        longint unsigned am = a % 256;
        return 16'((am * am + isqrt(b)) % 65536);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Model: accepted request keeps the unit busy for 25 cycles, then publishes its result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_y = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_y = m_pend;
        end else if (start_i) begin
            m_left = 25;
            m_pend = f(a_bi, b_bi);
        end
    end

    always @(negedge clk) begin
        chk("busy_vs_model", {31'd0, busy_o}, {31'd0, m_left != 0});
        chk("y_vs_model", {16'd0, y_bo}, {16'd0, m_y});
    end

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (busy_o === 1'b1 && cnt < 60) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(logic [31:0] a, logic [31:0] b, logic [15:0] exp, string nm);
        int c;
        @(negedge clk);
        a_bi = a; b_bi = b; start_i = 1;
        @(negedge clk);
        start_i = 0; a_bi = $urandom; b_bi = $urandom;
        wait_done(c);
        chk({nm, "_busy_cycles"}, c, 25);
        chk({nm, "_y"}, {16'd0, y_bo}, {16'd0, exp});
        chk({nm, "_busy_low"}, {31'd0, busy_o}, 0);
    endtask

    initial begin
        start_i = 1; a_bi = $urandom; b_bi = $urandom;
        repeat (4) begin
            @(negedge clk);
            chk("reset_busy", {31'd0, busy_o}, 0);
            chk("reset_y", {16'd0, y_bo}, 0);
            a_bi = $urandom; b_bi = $urandom;
        end
        start_i = 0; rst_n = 1;
        repeat (2) @(negedge clk);

        do_op(5, 16, 16'd29, "basic");
        do_op(32'h000001FF, 32'hFFFFFFFF, 16'hFE00, "wrap");

        @(negedge clk);
        a_bi = 3; b_bi = 9; start_i = 1;
        @(negedge clk);
        n = 0;
        while (busy_o === 1'b1 && n < 60) begin
            n++;
            if (n == 5) begin start_i = 1; a_bi = 10; b_bi = 100; end
            else begin start_i = 0; a_bi = $urandom; b_bi = $urandom; end
            @(negedge clk);
        end
        chk("busy_start_cycles", n, 25);
        chk("busy_start_y", {16'd0, y_bo}, 12);
        repeat (5) begin
            @(negedge clk);
            chk("busy_start_idle", {31'd0, busy_o}, 0);
        end

        @(negedge clk);
        a_bi = 9; b_bi = 81; start_i = 1;
        @(negedge clk);
        start_i = 0;
        repeat (10) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("async_rst_busy", {31'd0, busy_o}, 0);
        chk("async_rst_y", {16'd0, y_bo}, 0);
        @(negedge clk);
        rst_n = 1;
        do_op(2, 2, 16'd5, "after_rst");

        @(negedge clk);
        a_bi = 7; b_bi = 50; start_i = 1;
        @(negedge clk);
        wait_done(n);
        chk("b2b_first_cycles", n, 25);
        chk("b2b_first_y", {16'd0, y_bo}, 56);
        @(negedge clk);
        chk("b2b_rerise", {31'd0, busy_o}, 1);
        chk("b2b_hold_y", {16'd0, y_bo}, 56);
        start_i = 0;
        wait_done(n);
        chk("b2b_second_cycles", n, 25);
        chk("b2b_second_y", {16'd0, y_bo}, 56);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
